// File: rtl/ecore_dbus_responder.sv
// ecore_dbus_responder: completes the ecore data port's load/store requests.
// One request is outstanding at a time, and each completes with a registered
// one-cycle ack. Word addresses decode to on-chip RAM (addr[29]=0) or to an
// IO page (addr[29]=1). The IO page holds a GPIO bank and a free-running
// cycle counter.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for i_req; the request is accepted and writes commit
//   WAIT   | extra wait states, counted down from WAIT_CYCLES-1 to 0
//   RESP   | o_ack high for this cycle; read data is on o_rdata
module ecore_dbus_responder #(
  parameter int RAM_WORDS     = 1024,
  parameter int RAM_WORDS_LOG = 10,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [3:0]  i_be,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  inout  wire  [31:0] io_gpio_bank
);

  localparam logic [3:0] IO_GPIO_OUT = 4'd0;
  localparam logic [3:0] IO_GPIO_DIR = 4'd1;
  localparam logic [3:0] IO_GPIO_IN  = 4'd2;
  localparam logic [3:0] IO_CYCLE    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic [31:0] gpio_out_q, gpio_out_d;
  logic [31:0] gpio_dir_q, gpio_dir_d;
  logic [31:0] gpio_sync1_q;
  logic [31:0] gpio_in_q;
  logic [31:0] cycle_q, cycle_d;

  logic [31:0] ram_mem [RAM_WORDS];

  logic                     accept;
  logic                     io_wr;
  logic                     ram_wr;
  logic [RAM_WORDS_LOG-1:0] ram_wr_idx;
  logic [29:0]              rd_addr;
  logic                     rd_we;
  logic [31:0]              rd_word;
  logic                     unused_addr_bits;

  // Keep the old byte wherever the byte enable is clear.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Writes commit on the accept edge, so they use the live request inputs.
  // Only the address and direction are held for the later read sample.
  assign accept     = (state_q == ST_IDLE) && i_req && !i_rst;
  assign ram_wr     = accept && i_we && !i_addr[29];
  assign io_wr      = accept && i_we && i_addr[29];
  assign ram_wr_idx = i_addr[RAM_WORDS_LOG-1:0];

  // With no wait states the read is sampled on the accept edge itself.
  assign rd_addr = (state_q == ST_IDLE) ? i_addr : addr_q;
  assign rd_we   = (state_q == ST_IDLE) ? i_we   : we_q;

  // The middle address bits select nothing in either region.
  assign unused_addr_bits = ^rd_addr[28:RAM_WORDS_LOG];

  // Each GPIO pin is driven only when its direction bit selects output.
  for (genvar g = 0; g < 32; g++) begin : g_gpio_pad
    assign io_gpio_bank[g] = gpio_dir_q[g] ? gpio_out_q[g] : 1'bz;
  end

  // Read mux over RAM and the IO page; unmapped IO offsets read as zero.
  always_comb begin
    rd_word = 32'h0;
    if (!rd_addr[29]) begin
      rd_word = ram_mem[rd_addr[RAM_WORDS_LOG-1:0]];
    end else begin
      case (rd_addr[3:0])
        IO_GPIO_OUT: rd_word = gpio_out_q;
        IO_GPIO_DIR: rd_word = gpio_dir_q;
        IO_GPIO_IN:  rd_word = gpio_in_q;
        IO_CYCLE:    rd_word = cycle_q;
        default:     rd_word = 32'h0;
      endcase
    end
  end

  // Next-state logic for the FSM, the registered outputs and the IO registers.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    gpio_out_d = gpio_out_q;
    gpio_dir_d = gpio_dir_q;
    cycle_d    = cycle_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          addr_d = i_addr;
          we_d   = i_we;
          if (WAIT_CYCLES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (io_wr && (i_addr[3:0] == IO_GPIO_OUT)) begin
      gpio_out_d = merge_bytes(gpio_out_q, i_wdata, i_be);
    end
    if (io_wr && (i_addr[3:0] == IO_GPIO_DIR)) begin
      gpio_dir_d = merge_bytes(gpio_dir_q, i_wdata, i_be);
    end

    // RESP is always entered from IDLE or WAIT, so it lasts exactly one cycle.
    ack_d   = (state_d == ST_RESP);
    rdata_d = ((state_d == ST_RESP) && !rd_we) ? rd_word : 32'h0;
    busy_d  = (state_d != ST_IDLE);
  end

  // State, output and IO register update with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      addr_q       <= 30'h0;
      we_q         <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= 32'h0;
      busy_q       <= 1'b0;
      gpio_out_q   <= 32'h0;
      gpio_dir_q   <= 32'h0;
      gpio_sync1_q <= 32'h0;
      gpio_in_q    <= 32'h0;
      cycle_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      gpio_out_q   <= gpio_out_d;
      gpio_dir_q   <= gpio_dir_d;
      gpio_sync1_q <= io_gpio_bank;
      gpio_in_q    <= gpio_sync1_q;
      cycle_q      <= cycle_d;
    end
  end

  // RAM write port; contents are deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (ram_wr) begin
      ram_mem[ram_wr_idx] <= merge_bytes(ram_mem[ram_wr_idx], i_wdata, i_be);
    end
  end

  assign o_ack   = ack_q;
  assign o_rdata = rdata_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_ecore_dbus_responder.sv
// Testbench for ecore_dbus_responder. Two instances are used: one with no
// wait states and one with three. Stimulus pushes the expected responses into
// per-instance queues, and a negedge monitor pops and compares them on every ack.
module tb_ecore_dbus_responder;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    int          cyc;
  } exp_t;

  localparam logic [29:0] IO = 30'h2000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q3[$];

  logic        rst0, req0, we0, ack0, busy0;
  logic [3:0]  be0;
  logic [29:0] addr0;
  logic [31:0] wdata0, rdata0;
  wire  [31:0] pins0;

  logic        rst3, req3, we3, ack3, busy3;
  logic [3:0]  be3;
  logic [29:0] addr3;
  logic [31:0] wdata3, rdata3;
  wire  [31:0] pins3;

  ecore_dbus_responder #(.RAM_WORDS(1024), .RAM_WORDS_LOG(10), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst0), .i_req(req0), .i_we(we0), .i_be(be0),
    .i_addr(addr0), .i_wdata(wdata0), .o_ack(ack0), .o_rdata(rdata0),
    .o_busy(busy0), .io_gpio_bank(pins0)
  );

  ecore_dbus_responder #(.RAM_WORDS(1024), .RAM_WORDS_LOG(10), .WAIT_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_we(we3), .i_be(be3),
    .i_addr(addr3), .i_wdata(wdata3), .o_ack(ack3), .o_rdata(rdata3),
    .o_busy(busy3), .io_gpio_bank(pins3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_step(input int id, input logic ack, input logic [31:0] rd);
    exp_t e;
    if (ack) begin
      if ((id == 0 && q0.size() == 0) || (id == 3 && q3.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_ack: got ack=1 expected no ack (t=%0t)", id, $time);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q3.pop_front();
        chk($sformatf("dut%0d_rdata", id), rd & e.mask, e.data & e.mask);
        chk($sformatf("dut%0d_ack_cycle", id), 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk($sformatf("dut%0d_idle_rdata", id), rd, 32'h0);
    end
  endtask

  // Monitor: compares every ack against the scoreboard queues.
  always @(negedge clk) begin
    mon_step(0, ack0, rdata0);
    mon_step(3, ack3, rdata3);
  end

  task automatic wait_idle(input int id);
    int n = 0;
    while (((id == 0) ? busy0 : busy3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_busy_timeout: got busy=1 expected 0 within 50 cycles", id);
    end
  endtask

  // One request, held for a single cycle; the expected read data and ack cycle are queued.
  task automatic xact(input int id, input logic w, input logic [3:0] be, input logic [29:0] a,
                      input logic [31:0] wd, input logic [31:0] exp, input logic [31:0] mask);
    exp_t e;
    wait_idle(id);
    e.data = w ? 32'h0 : exp;
    e.mask = w ? 32'hFFFF_FFFF : mask;
    e.cyc  = cyc + ((id == 0) ? 1 : 4);
    if (id == 0) begin
      we0 = w; be0 = be; addr0 = a; wdata0 = wd; req0 = 1'b1;
      q0.push_back(e);
    end else begin
      we3 = w; be3 = be; addr3 = a; wdata3 = wd; req3 = 1'b1;
      q3.push_back(e);
    end
    @(negedge clk);
    req0 = 1'b0;
    req3 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n0;
    int   n;
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = 30'h0; wdata0 = 32'h0;
    rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; be3 = 4'h0; addr3 = 30'h0; wdata3 = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_ack0", 32'(ack0), 32'h0);
    chk("reset_busy0", 32'(busy0), 32'h0);
    chk("reset_rdata0", rdata0, 32'h0);
    chk("reset_busy3", 32'(busy3), 32'h0);
    rst0 = 1'b0;
    rst3 = 1'b0;

    // Cycle counter read at the third cycle after reset release.
    repeat (3) @(negedge clk);
    xact(0, 1'b0, 4'hF, IO + 30'd3, 32'h0, 32'd3, 32'hFFFF_FFFF);

    // RAM write/read, byte enables, no-op write, aliasing.
    xact(0, 1'b1, 4'hF, 30'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
    xact(0, 1'b0, 4'hF, 30'd5, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    xact(0, 1'b1, 4'b0101, 30'd5, 32'h0000_0000, 32'h0, 32'h0);
    xact(0, 1'b0, 4'h0, 30'd5, 32'h0, 32'hDE00_BE00, 32'hFFFF_FFFF);
    xact(0, 1'b1, 4'h0, 30'd5, 32'hFFFF_FFFF, 32'h0, 32'h0);
    xact(0, 1'b0, 4'hF, 30'd1029, 32'h0, 32'hDE00_BE00, 32'hFFFF_FFFF);

    // GPIO: low byte as outputs, then the synchronizer delay on GPIO_IN.
    xact(0, 1'b1, 4'hF, IO + 30'd1, 32'h0000_00FF, 32'h0, 32'h0);
    xact(0, 1'b1, 4'hF, IO + 30'd0, 32'h0000_00A5, 32'h0, 32'h0);
    chk("pins0_low_byte", {24'h0, pins0[7:0]}, 32'h0000_00A5);
    xact(0, 1'b0, 4'hF, IO + 30'd2, 32'h0, 32'h0000_0000, 32'h0000_00FF);
    xact(0, 1'b0, 4'hF, IO + 30'd2, 32'h0, 32'h0000_00A5, 32'h0000_00FF);
    xact(0, 1'b0, 4'hF, IO + 30'd0, 32'h0, 32'h0000_00A5, 32'hFFFF_FFFF);
    xact(0, 1'b0, 4'hF, 30'h2FFF_FFF1, 32'h0, 32'h0000_00FF, 32'hFFFF_FFFF);
    xact(0, 1'b1, 4'hF, IO + 30'd7, 32'hFFFF_FFFF, 32'h0, 32'h0);
    xact(0, 1'b0, 4'hF, IO + 30'd7, 32'h0, 32'h0, 32'hFFFF_FFFF);
    xact(0, 1'b1, 4'hF, IO + 30'd2, 32'hFFFF_FFFF, 32'h0, 32'h0);
    xact(0, 1'b0, 4'hF, IO + 30'd0, 32'h0, 32'h0000_00A5, 32'hFFFF_FFFF);
    xact(0, 1'b1, 4'hF, IO + 30'd1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    xact(0, 1'b1, 4'hF, IO + 30'd0, 32'h1234_5678, 32'h0, 32'h0);
    xact(0, 1'b0, 4'hF, IO + 30'd2, 32'h0, 32'h0000_00A5, 32'hFFFF_FFFF);
    xact(0, 1'b0, 4'hF, IO + 30'd2, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    xact(0, 1'b1, 4'b1110, IO + 30'd1, 32'h0000_0000, 32'h0, 32'h0);
    xact(0, 1'b0, 4'hF, IO + 30'd1, 32'h0, 32'h0000_00FF, 32'hFFFF_FFFF);

    // Cycle counter preloaded near wrap; a write to it is ignored.
    wait_idle(0);
    force u_dut0.cycle_q = 32'hFFFF_FFFE;
    #1;
    release u_dut0.cycle_q;
    xact(0, 1'b0, 4'hF, IO + 30'd3, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    xact(0, 1'b0, 4'hF, IO + 30'd3, 32'h0, 32'h0000_0000, 32'hFFFF_FFFF);
    xact(0, 1'b0, 4'hF, IO + 30'd3, 32'h0, 32'h0000_0002, 32'hFFFF_FFFF);
    xact(0, 1'b1, 4'hF, IO + 30'd3, 32'h0, 32'h0, 32'h0);
    xact(0, 1'b0, 4'hF, IO + 30'd3, 32'h0, 32'h0000_0006, 32'hFFFF_FFFF);

    // Three wait states: request held for 10 cycles, aliasing read of RAM[1024].
    xact(3, 1'b1, 4'hF, 30'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
    wait_idle(3);
    we3 = 1'b0; be3 = 4'hF; addr3 = 30'd1024; wdata3 = 32'h0; req3 = 1'b1;
    n0 = cyc;
    e.data = 32'hCAFE_F00D; e.mask = 32'hFFFF_FFFF; e.cyc = n0 + 4;
    q3.push_back(e);
    e.cyc = n0 + 9;
    q3.push_back(e);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("busy3_k%0d", k), 32'(busy3),
          ((k >= 1 && k <= 4) || (k >= 6 && k <= 9)) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    req3 = 1'b0;

    // Reset during WAIT: no ack, registers cleared, committed write kept.
    xact(3, 1'b1, 4'hF, IO + 30'd1, 32'h0000_FFFF, 32'h0, 32'h0);
    xact(3, 1'b1, 4'hF, IO + 30'd0, 32'h0000_AAAA, 32'h0, 32'h0);
    xact(3, 1'b0, 4'hF, IO + 30'd1, 32'h0, 32'h0000_FFFF, 32'hFFFF_FFFF);
    wait_idle(3);
    we3 = 1'b1; be3 = 4'hF; addr3 = 30'd7; wdata3 = 32'h1234_5678; req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    chk("busy3_in_wait", 32'(busy3), 32'h1);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    chk("rst3_ack", 32'(ack3), 32'h0);
    chk("rst3_busy", 32'(busy3), 32'h0);
    chk("rst3_rdata", rdata3, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    repeat (3) @(negedge clk);
    xact(3, 1'b0, 4'hF, IO + 30'd1, 32'h0, 32'h0000_0000, 32'hFFFF_FFFF);
    xact(3, 1'b0, 4'hF, IO + 30'd0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFF);
    xact(3, 1'b0, 4'hF, 30'd7, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    xact(3, 1'b0, 4'hF, 30'd0, 32'h0, 32'hCAFE_F00D, 32'hFFFF_FFFF);

    n = 0;
    while ((q0.size() != 0 || q3.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending acks expected 0/0", q0.size(), q3.size());
    end
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
